// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter for one FIFO write port; the owner keeps the port until last or MAX_BEATS beats.
// One-cycle arbitration, one IDLE cycle between packets; fifo_full_i stalls the owner combinationally, so no beat is dropped.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]       req_last_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [WIDTH-1:0]         fifo_wdata_o,
  output logic                     fifo_we_o,
  input  logic                     fifo_full_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     err_o,
  input  logic                     err_clr_i
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int CAW = IW + 1;
  localparam int CW  = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state, state_d;
  logic [NUM_REQ-1:0] grant, grant_d;
  logic [IW-1:0]      rr_last, rr_last_d;
  logic [CW-1:0]      beat_cnt, beat_cnt_d;
  logic               err, err_d;

  logic [IW-1:0]      pick;
  logic               pick_vld;
  logic [CAW-1:0]     cand;
  logic [IW-1:0]      owner;
  logic               own_vld;
  logic               own_last;
  logic               xfer;
  logic               at_limit;
  logic               forced;

  // Scanning offsets high to low lets the nearest valid requester after rr_last win.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = {1'b0, rr_last} + CAW'(i);
      if (cand >= CAW'(NUM_REQ)) begin
        cand = cand - CAW'(NUM_REQ);
      end
      if (req_valid_i[cand[IW-1:0]]) begin
        pick     = cand[IW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    owner        = '0;
    fifo_wdata_o = '0;
    own_vld      = 1'b0;
    own_last     = 1'b0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (grant[n]) begin
        owner        = IW'(n);
        fifo_wdata_o = req_data_i[n*WIDTH +: WIDTH];
        own_vld      = req_valid_i[n];
        own_last     = req_last_i[n];
      end
    end
  end

  assign xfer        = (state == LOCKED) && own_vld && !fifo_full_i;
  assign fifo_we_o   = xfer;
  assign req_ready_o = ((state == LOCKED) && !fifo_full_i) ? grant : '0;
  assign at_limit    = (beat_cnt + CW'(1)) == CW'(MAX_BEATS);
  assign grant_o     = grant;
  assign err_o       = err;

  always_comb begin
    state_d    = state;
    grant_d    = grant;
    rr_last_d  = rr_last;
    beat_cnt_d = beat_cnt;
    forced     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_d    = LOCKED;
          grant_d    = NUM_REQ'(1) << pick;
          beat_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt + CW'(1);
          if (own_last || at_limit) begin
            state_d   = IDLE;
            grant_d   = '0;
            rr_last_d = owner;
            forced    = !own_last;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    // A forced release in the same cycle as a clear keeps the flag set.
    err_d = forced ? 1'b1 : (err_clr_i ? 1'b0 : err);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      grant    <= '0;
      rr_last  <= IW'(NUM_REQ - 1);
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      rr_last  <= rr_last_d;
      beat_cnt <= beat_cnt_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester beat queues drive the DUT; a packet-level round-robin model predicts FIFO contents.
module tb_fifo_wr_arbiter;
  localparam int NR   = 4;
  localparam int W    = 32;
  localparam int MAXB = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR*W-1:0]   req_data_i;
  logic [NR-1:0]     req_last_i;
  logic [NR-1:0]     req_ready_o;
  logic [W-1:0]      fifo_wdata_o;
  logic              fifo_we_o;
  logic              fifo_full_i;
  logic [NR-1:0]     grant_o;
  logic              err_o;
  logic              err_clr_i;

  int vectors;
  int miscompares;
  int m_rr;
  bit m_err;

  beat_t        rq [NR][$];
  logic [W-1:0] exp_dat[$];
  int           exp_own[$];
  bit           exp_new[$];
  bit           exp_err[$];
  logic [W-1:0] obs_dat[$];
  int           obs_own[$];
  int           obs_cyc[$];
  bit           obs_err[$];

  fifo_wr_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_BEATS(MAXB)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o),
    .fifo_wdata_o(fifo_wdata_o), .fifo_we_o(fifo_we_o), .fifo_full_i(fifo_full_i),
    .grant_o(grant_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  function automatic int owner_of(input logic [NR-1:0] g);
    int r;
    r = -1;
    for (int n = 0; n < NR; n++) if (g[n]) r = n;
    return r;
  endfunction

  task automatic drive_req(input int n, input logic v, input logic [W-1:0] d, input logic l);
    req_valid_i[n]          = v;
    req_data_i[n*W +: W]    = d;
    req_last_i[n]           = l;
  endtask

  task automatic push_beat(input int n, input logic [W-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    rq[n].push_back(b);
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    req_valid_i = '0;
    fifo_full_i = 1'b0;
    err_clr_i = 1'b0;
    for (int n = 0; n < NR; n++) rq[n].delete();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    m_rr  = NR - 1;
    m_err = 1'b0;
  endtask

  // Packet-level model: pick the next non-empty requester after the last owner,
  // take beats until last or MAXB beats (the latter being a forced release).
  task automatic build_expect();
    beat_t cq [NR][$];
    beat_t b;
    int    n, cnt;
    bit    done;
    for (int i = 0; i < NR; i++) cq[i] = rq[i];
    exp_dat.delete(); exp_own.delete(); exp_new.delete(); exp_err.delete();
    while (1) begin
      n = -1;
      for (int k = NR; k >= 1; k--) if (cq[(m_rr + k) % NR].size() > 0) n = (m_rr + k) % NR;
      if (n < 0) break;
      cnt  = 0;
      done = 0;
      while (!done) begin
        if (cq[n].size() == 0) break;
        b = cq[n].pop_front();
        cnt++;
        exp_dat.push_back(b.data);
        exp_own.push_back(n);
        exp_new.push_back(cnt == 1);
        exp_err.push_back(m_err);
        if (b.last) done = 1;
        else if (cnt == MAXB) begin
          done  = 1;
          m_err = 1'b1;
        end
      end
      m_rr = n;
    end
  endtask

  task automatic run_traffic(input string tag, input int budget, input int full_pct,
                             input logic [31:0] full_pat, input bit chk_gap);
    int cyc, lim;
    bit pend;
    logic [NR-1:0] pop;
    obs_dat.delete(); obs_own.delete(); obs_cyc.delete(); obs_err.delete();
    cyc  = 0;
    pend = 0;
    for (int n = 0; n < NR; n++) if (rq[n].size() > 0) pend = 1;
    while (pend && cyc < budget) begin
      @(negedge clk_i);
      fifo_full_i = (cyc < 32) ? full_pat[cyc] : (int'($urandom_range(99)) < full_pct);
      for (int n = 0; n < NR; n++) begin
        if (rq[n].size() > 0) drive_req(n, 1'b1, rq[n][0].data, rq[n][0].last);
        else drive_req(n, 1'b0, '0, 1'b0);
      end
      #1;
      vectors++;
      if (fifo_we_o && fifo_full_i) begin
        miscompares++;
        $display("FAIL %s we_while_full cyc=%0d: we=%b full=%b, required we=0", tag, cyc, fifo_we_o, fifo_full_i);
      end
      vectors++;
      if ((req_ready_o & ~grant_o) != 0 || (fifo_full_i && req_ready_o != 0) || !$onehot0(grant_o)) begin
        miscompares++;
        $display("FAIL %s ready_grant cyc=%0d: ready=%b grant=%b full=%b, required ready only for the owner and 0 when full",
                 tag, cyc, req_ready_o, grant_o, fifo_full_i);
      end
      vectors++;
      if (fifo_we_o !== ((|(grant_o & req_valid_i)) && !fifo_full_i)) begin
        miscompares++;
        $display("FAIL %s we_rule cyc=%0d: we=%b, required %b", tag, cyc, fifo_we_o,
                 (|(grant_o & req_valid_i)) && !fifo_full_i);
      end
      if (fifo_we_o) begin
        obs_dat.push_back(fifo_wdata_o);
        obs_own.push_back(owner_of(grant_o));
        obs_cyc.push_back(cyc);
        obs_err.push_back(err_o);
      end
      pop = req_ready_o & req_valid_i;
      @(posedge clk_i);
      for (int n = 0; n < NR; n++) if (pop[n]) void'(rq[n].pop_front());
      pend = 0;
      for (int n = 0; n < NR; n++) if (rq[n].size() > 0) pend = 1;
      cyc++;
    end
    @(negedge clk_i);
    req_valid_i = '0;
    req_last_i  = '0;
    fifo_full_i = 1'b0;
    vectors++;
    if (pend) begin
      miscompares++;
      $display("FAIL %s timeout: beats still queued after %0d cycles, required all drained", tag, budget);
    end
    vectors++;
    if (obs_dat.size() != exp_dat.size()) begin
      miscompares++;
      $display("FAIL %s write_count: got %0d writes, required %0d", tag, obs_dat.size(), exp_dat.size());
    end
    lim = (obs_dat.size() < exp_dat.size()) ? obs_dat.size() : exp_dat.size();
    for (int j = 0; j < lim; j++) begin
      vectors++;
      if (obs_dat[j] !== exp_dat[j] || obs_own[j] != exp_own[j]) begin
        miscompares++;
        $display("FAIL %s write[%0d]: data=%h owner=%0d, required data=%h owner=%0d",
                 tag, j, obs_dat[j], obs_own[j], exp_dat[j], exp_own[j]);
      end
      vectors++;
      if (obs_err[j] !== exp_err[j]) begin
        miscompares++;
        $display("FAIL %s err_at_write[%0d]: err=%b, required %b", tag, j, obs_err[j], exp_err[j]);
      end
      if (chk_gap && j > 0) begin
        vectors++;
        if (obs_cyc[j] - obs_cyc[j-1] != (exp_new[j] ? 2 : 1)) begin
          miscompares++;
          $display("FAIL %s gap[%0d]: %0d cycles since previous write, required %0d",
                   tag, j, obs_cyc[j] - obs_cyc[j-1], exp_new[j] ? 2 : 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    fifo_full_i = 1'b0;
    err_clr_i = 1'b0;
    for (int n = 0; n < NR; n++) drive_req(n, 1'b1, 32'hC0 + n, 1'b1);
    repeat (2) @(negedge clk_i);
    #1;
    vectors++;
    if (grant_o !== '0 || fifo_we_o !== 1'b0 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: grant=%b we=%b err=%b, required 0000 0 0", grant_o, fifo_we_o, err_o);
    end
    vectors++;
    if (req_ready_o !== '0 || fifo_wdata_o !== '0) begin
      miscompares++;
      $display("FAIL reset_datapath: ready=%b wdata=%h, required 0000 00000000", req_ready_o, fifo_wdata_o);
    end
    rst_i = 1'b0;
    #1;
    vectors++;
    if (grant_o !== '0 || fifo_we_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: grant=%b we=%b, required 0000 0", grant_o, fifo_we_o);
    end
    @(negedge clk_i);
    #1;
    vectors++;
    if (grant_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL first_grant: grant=%b, required 0001", grant_o);
    end
    vectors++;
    if (fifo_we_o !== 1'b1 || fifo_wdata_o !== 32'hC0) begin
      miscompares++;
      $display("FAIL first_write: we=%b wdata=%h, required 1 000000c0", fifo_we_o, fifo_wdata_o);
    end
    @(negedge clk_i);
    req_valid_i = '0;
    #1;
    vectors++;
    if (grant_o !== '0) begin
      miscompares++;
      $display("FAIL release_after_last: grant=%b, required 0000", grant_o);
    end
    m_rr = 0;
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int r = 0; r < 3; r++)
      for (int n = 0; n < NR; n++) push_beat(n, 32'hA0 + n, 1'b1);
    build_expect();
    run_traffic("round_robin", 200, 0, 32'h0, 1'b1);
  endtask

  task automatic test_packet_lock();
    push_beat(1, 32'h01, 1'b1);
    push_beat(1, 32'h55, 1'b1);
    push_beat(2, 32'h10, 1'b0);
    push_beat(2, 32'h11, 1'b0);
    push_beat(2, 32'h12, 1'b1);
    build_expect();
    run_traffic("packet_lock", 100, 0, 32'h0, 1'b1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) push_beat(0, $urandom, i == 3);
    build_expect();
    run_traffic("backpressure", 100, 0, 32'h0000_0038, 1'b0);
  endtask

  task automatic test_beat_limit();
    for (int i = 0; i < 6; i++) push_beat(0, 32'hB0 + i, 1'b0);
    build_expect();
    run_traffic("beat_limit", 100, 0, 32'h0, 1'b1);
    #1;
    vectors++;
    if (err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL beat_limit_err: err=%b, required 1", err_o);
    end
    vectors++;
    if (grant_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL beat_limit_rearb: grant=%b, required 0001 (second packet still open)", grant_o);
    end
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    #1;
    vectors++;
    if (err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: err=%b, required 0", err_o);
    end
    apply_reset();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d[5];
    int k, cyc;
    for (int i = 0; i < 5; i++) d[i] = $urandom;
    k = 0;
    cyc = 0;
    while (k < 2 && cyc < 20) begin
      @(negedge clk_i);
      drive_req(0, 1'b1, d[k], 1'b0);
      #1;
      if (fifo_we_o) begin
        vectors++;
        if (fifo_wdata_o !== d[k]) begin
          miscompares++;
          $display("FAIL reset_mid_beat%0d: wdata=%h, required %h", k, fifo_wdata_o, d[k]);
        end
        k++;
      end
      cyc++;
    end
    vectors++;
    if (k != 2) begin
      miscompares++;
      $display("FAIL reset_mid_timeout: %0d beats written, required 2", k);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    drive_req(0, 1'b1, d[2], 1'b0);
    @(negedge clk_i);
    #1;
    vectors++;
    if (fifo_we_o !== 1'b0 || grant_o !== '0 || req_ready_o !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_stop: we=%b grant=%b ready=%b, required 0 0000 0000", fifo_we_o, grant_o, req_ready_o);
    end
    rst_i = 1'b0;
    drive_req(0, 1'b0, '0, 1'b0);
    m_rr  = NR - 1;
    m_err = 1'b0;
    push_beat(3, 32'h33, 1'b1);
    push_beat(0, 32'h30, 1'b1);
    build_expect();
    run_traffic("reset_mid_rr", 50, 0, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    int npk, len;
    for (int it = 0; it < 8; it++) begin
      for (int n = 0; n < NR; n++) begin
        npk = $urandom_range(2);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 7);
          for (int b = 0; b < len; b++) push_beat(n, $urandom, b == len - 1);
        end
      end
      build_expect();
      run_traffic("random", 600, 25, 32'h0, 1'b0);
      #1;
      vectors++;
      if (err_o !== m_err || grant_o !== '0) begin
        miscompares++;
        $display("FAIL random_end it=%0d: err=%b grant=%b, required err=%b grant=0000", it, err_o, grant_o, m_err);
      end
      if (m_err) begin
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        #1;
        vectors++;
        if (err_o !== 1'b0) begin
          miscompares++;
          $display("FAIL random_err_clear it=%0d: err=%b, required 0", it, err_o);
        end
        m_err = 1'b0;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_rr        = NR - 1;
    m_err       = 1'b0;
    rst_i       = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    fifo_full_i = 1'b0;
    err_clr_i   = 1'b0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_beat_limit();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

- Round-robin arbiter that shares the single write port of a `sync_fifo` instance among `NUM_REQ` requesters.
- Each requester offers packets as valid/ready beats terminated by `last`.
- Once a requester is granted, it keeps the FIFO until its packet ends, so packets never interleave in the FIFO.
- The block sits directly in front of the FIFO's `wdata_i`/`we_i`/`full_o` and adds a per-packet beat limit with a sticky error flag.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `WIDTH`, default 32: data width; must match the FIFO `WIDTH`.
- `MAX_BEATS`, default 16: beat limit per packet; forced release when it is reached.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  NUM_REQ  per-requester beat valid.
- `req_data_i`  in  NUM_REQ*WIDTH  requester n data is in bits [n*WIDTH +: WIDTH].
- `req_last_i`  in  NUM_REQ  per-requester end-of-packet marker, qualified by valid.
- `req_ready_o`  out  NUM_REQ  per-requester beat accept.
- `fifo_wdata_o`  out  WIDTH  to FIFO `wdata_i`.
- `fifo_we_o`  out  1  to FIFO `we_i`.
- `fifo_full_i`  in  1  from FIFO `full_o`.
- `grant_o`  out  NUM_REQ  one-hot current owner; 0 when idle.
- `err_o`  out  1  sticky; set on a beat-limit overrun.
- `err_clr_i`  in  1  clears `err_o`.

## Operation
- **States:** IDLE and LOCKED.
- **Registered state:** `state`, `grant` (one-hot), `rr_last` (index of the last owner), `beat_cnt` ($clog2(MAX_BEATS+1) bits), `err`.
- **IDLE:**
  - If any `req_valid_i` is set, select the first set bit searching `rr_last+1, rr_last+2, …`, wrapping modulo NUM_REQ.
  - Register that grant, load `beat_cnt`=0 and go to LOCKED.
  - Otherwise stay in IDLE.
  - `req_ready_o`=0 and `fifo_we_o`=0 throughout IDLE.
- **LOCKED, owner g:**
  - `req_ready_o[g]` = ~`fifo_full_i`; all other ready bits are 0.
  - `fifo_we_o` = `req_valid_i[g]` & ~`fifo_full_i`.
  - `fifo_wdata_o` = data slice g. It is driven with g's slice whenever LOCKED, and is 0 in IDLE.
  - A beat transfers when `fifo_we_o`=1; each transfer increments `beat_cnt`.
  - A transfer with `req_last_i[g]`=1 ends the packet: go to IDLE, `rr_last`<=g, `grant`<=0.
  - A transfer without last that brings `beat_cnt` to MAX_BEATS also ends the packet the same way and sets `err`<=1 (forced release). Later beats from g are arbitrated as a new packet.
  - Valid low or FIFO full: hold the state; `beat_cnt` unchanged.
- **`err_o`:**
  - Set by a forced release.
  - Cleared by `err_clr_i` when no forced release occurs in the same cycle.
  - Set wins over clear.
- **Requester contract:**
  - Once `req_valid_i[n]` is asserted, data and last are held until ready.
  - The arbiter does not depend on this for correctness; it only samples data on transfer.

## Timing
- **Reset** (`rst_i`=1 at a clock edge):
  - State IDLE, `grant_o`=0, `rr_last`=NUM_REQ-1 (requester 0 has first priority), `beat_cnt`=0, `err_o`=0.
  - Combinational outputs follow: `req_ready_o`=0, `fifo_we_o`=0, `fifo_wdata_o`=0.
- Reset asserted mid-packet abandons the packet; no further FIFO writes occur from the following cycle.
- **Arbitration latency:** one cycle. Valid seen in IDLE in cycle t gives grant and ready in cycle t+1 at the earliest.
- **Streaming:** one beat per cycle while LOCKED, the owner is valid and the FIFO is not full.
- **Gap between packets:** at least one IDLE cycle. Back-to-back single-beat packets therefore sustain 1 beat per 2 cycles.
- **Datapath:** `fifo_we_o`, `req_ready_o` and `fifo_wdata_o` are combinational from registered state plus `fifo_full_i`/`req_*`; there are no extra pipeline stages.
- **FIFO full:** the FIFO ignores writes when full. This block never asserts `fifo_we_o` while `fifo_full_i`=1, so no beat is lost.
- **Simultaneous requests in IDLE:** exactly one grant, per the round-robin order.
- **Starvation bound:** a requester with valid asserted is granted within NUM_REQ packets.

## Test plan
- **Reset:** hold `rst_i`=1 for 2 cycles with all valids=1 -> `grant_o`=0, `fifo_we_o`=0, `err_o`=0. The first grant after release goes to requester 0, at cycle 1 after deassert.
- **Round-robin:**
  - Stimulus: all 4 requesters send continuous 1-beat packets with distinct data 0xA0+n.
  - Required: FIFO receives A0, A1, A2, A3, A0… and `grant_o` cycles 0001, 0010, 0100, 1000, with one IDLE cycle between grants.
- **Packet lock:**
  - Stimulus: requester 2 sends a 3-beat packet 0x10, 0x11, 0x12 (last on 0x12) while requester 1 is valid.
  - Required: FIFO receives 10, 11, 12 contiguously, then requester 1 is granted; `req_ready_o[1]` stays 0 until then.
- **Backpressure:**
  - Stimulus: `fifo_full_i`=1 for 3 cycles in the middle of a 4-beat packet.
  - Required: `fifo_we_o`=0 and ready=0 during those cycles; all 4 beats are written in order with no duplicates.
- **Beat limit:**
  - Stimulus: MAX_BEATS=4; requester 0 sends 6 beats with no last.
  - Required: after the 4th transfer, the block goes to IDLE and `err_o`=1. Remaining beats are re-arbitrated as a new packet. `err_clr_i` pulse -> `err_o`=0 the next cycle.
- **Reset mid-packet:** assert `rst_i` after beat 2 of 5 -> no write in the following cycle, state IDLE, `rr_last` reset to 3.
